prf_wb_arbiter: RTL

Arbitrates functional-unit writeback requests onto the physical register file's write ports. Six FU result sources (4 ALU, LSU, MDU) compete for four PRF write ports each cycle. A rotating-priority grant drives a registered output stage, which feeds the PRF write vectors (`fu_result_vec`, `fu_wb_rd_index_vec`, `fu_wb_valid_vec`) and the IQ wakeup network. Requesters that lose arbitration hold their request under a valid/ready handshake.

---
 rtl/prf_wb_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/prf_wb_arbiter.sv
// PRF writeback arbiter: rotating-priority grant of N_REQ FU results onto N_PORT registered write ports.
// Optional duplicate-destination detector enabled by defining PRF_WB_ARB_DUP_CHECK_EN (adds sticky dup_err).
`ifndef PREG_INDEX_WIDTH
`define PREG_INDEX_WIDTH 6
`endif

module prf_wb_arbiter #(
  parameter int unsigned N_REQ  = 6,
  parameter int unsigned N_PORT = 4,
  parameter int unsigned PREG_W = `PREG_INDEX_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req_valid_vec,
  input  logic [PREG_W-1:0] req_preg_vec [N_REQ-1:0],
  input  logic [31:0]       req_data_vec [N_REQ-1:0],
  output logic [N_REQ-1:0]  req_ready_vec,
  input  logic              flush,
  output logic [N_PORT-1:0] fu_wb_valid_vec,
  output logic [PREG_W-1:0] fu_wb_rd_index_vec [N_PORT-1:0],
  output logic [31:0]       fu_result_vec [N_PORT-1:0],
  output logic [31:0]       stall_cnt
`ifdef PRF_WB_ARB_DUP_CHECK_EN
  ,
  output logic              dup_err
`endif
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]  r_rr_ptr;
  logic [N_PORT-1:0] r_wb_valid;
  logic [PREG_W-1:0] r_wb_index [N_PORT-1:0];
  logic [31:0]       r_wb_data  [N_PORT-1:0];
  logic [31:0]       r_stall_cnt;

  logic [N_REQ-1:0]  w_grant;
  logic [N_PORT-1:0] w_port_used;
  logic [PTR_W-1:0]  w_port_sel  [N_PORT-1:0];
  logic [PREG_W-1:0] w_port_preg [N_PORT-1:0];
  logic [31:0]       w_port_data [N_PORT-1:0];
  logic [PTR_W-1:0]  w_next_ptr;
  logic              w_refused;

  // Scan candidates from rr_ptr; the k-th valid one lands on port k, the rest wait.
  always_comb begin : grant_scan
    int unsigned      v_cnt;
    logic [PTR_W-1:0] v_idx;
    w_grant     = '0;
    w_port_used = '0;
    w_next_ptr  = r_rr_ptr;
    v_cnt       = 0;
    v_idx       = '0;
    for (int unsigned p = 0; p < N_PORT; p++) begin
      w_port_sel[p] = '0;
    end
    for (int unsigned c = 0; c < N_REQ; c++) begin
      v_idx = PTR_W'((32'(r_rr_ptr) + c) % N_REQ);
      if (req_valid_vec[v_idx] && (v_cnt < N_PORT)) begin
        w_grant[v_idx] = 1'b1;
        for (int unsigned p = 0; p < N_PORT; p++) begin
          if (v_cnt == p) begin
            w_port_sel[p]  = v_idx;
            w_port_used[p] = 1'b1;
          end
        end
        w_next_ptr = PTR_W'((32'(v_idx) + 1) % N_REQ);
        v_cnt++;
      end
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < N_PORT; p++) begin
      w_port_preg[p] = req_preg_vec[w_port_sel[p]];
      w_port_data[p] = req_data_vec[w_port_sel[p]];
    end
  end

  always_comb begin
    if (!rst_n) begin
      req_ready_vec = '0;
    end else if (flush) begin
      req_ready_vec = '1;
    end else begin
      req_ready_vec = w_grant;
    end
  end

  assign w_refused = |(req_valid_vec & ~w_grant);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_wb_valid  <= '0;
      r_stall_cnt <= '0;
      for (int unsigned p = 0; p < N_PORT; p++) begin
        r_wb_index[p] <= '0;
        r_wb_data[p]  <= '0;
      end
    end else if (flush) begin
      r_rr_ptr   <= '0;
      r_wb_valid <= '0;
    end else begin
      r_rr_ptr <= w_next_ptr;
      if (w_refused) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      // preg 0 consumes its slot but never writes
      for (int unsigned p = 0; p < N_PORT; p++) begin
        r_wb_valid[p] <= w_port_used[p] && (w_port_preg[p] != '0);
        r_wb_index[p] <= w_port_used[p] ? w_port_preg[p] : '0;
        r_wb_data[p]  <= w_port_used[p] ? w_port_data[p] : '0;
      end
    end
  end

  assign fu_wb_valid_vec    = r_wb_valid;
  assign fu_wb_rd_index_vec = r_wb_index;
  assign fu_result_vec      = r_wb_data;
  assign stall_cnt          = r_stall_cnt;

`ifdef PRF_WB_ARB_DUP_CHECK_EN
  logic w_dup_hit;
  logic r_dup_err;

  always_comb begin
    w_dup_hit = 1'b0;
    for (int unsigned a = 0; a < N_PORT; a++) begin
      for (int unsigned b = a + 1; b < N_PORT; b++) begin
        if (w_port_used[a] && w_port_used[b] &&
            (w_port_preg[a] == w_port_preg[b]) && (w_port_preg[a] != '0)) begin
          w_dup_hit = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dup_err <= 1'b0;
    end else if (!flush && w_dup_hit) begin
      r_dup_err <= 1'b1;
    end
  end

  assign dup_err = r_dup_err;
`endif

endmodule
